ahb_lsu_sequencer: RTL and testbench

Multi-cycle load/store sequencer between the MIPS core's control/datapath and the AHB-Lite bus. It takes one memory request per instruction (`mem_write`, `byte_control`, `arith_u` from the control unit plus the ALU address and rt data). It runs a single AHB-Lite NONSEQ transfer and stalls the core until the transfer completes. It returns byte-lane-selected, sign- or zero-extended load data and flags misaligned accesses and bus errors.

---
 rtl/ahb_lsu_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_ahb_lsu_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lsu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lsu_sequencer
// Description : Multi-cycle load/store sequencer between the MIPS core and an
//               AHB-Lite bus. One NONSEQ transfer per memory instruction; the
//               core is stalled until the transfer completes. Load data is
//               lane-selected and sign/zero-extended; misaligned accesses and
//               bus errors are reported through err.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined     : misaligned half/word accesses skip the bus, finish with err=1
//   not defined : HADDR low bits are forced to zero and the access proceeds
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n        : clock (shared with HCLK), synchronous active-low reset
//   req_valid         : memory instruction present, held until done
//   mem_write         : 1 = store, 0 = load
//   byte_control[1:0] : 0 word, 1 half, 2 byte, 3 word
//   arith_u           : 1 = zero-extend loads, 0 = sign-extend
//   addr, wdata       : effective address and store data
//   stall             : hold the core pipeline
//   done, rdata, err  : completion pulse, extended load data, error flag
//   HADDR..HWDATA     : AHB-Lite master outputs
//   HRDATA,HREADY,HRESP : AHB-Lite slave response
// ============================================================================
module ahb_lsu_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              mem_write,
  input  logic [1:0]        byte_control,
  input  logic              arith_u,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] SIZE_BYTE = 3'd0;
  localparam logic [2:0] SIZE_HALF = 3'd1;
  localparam logic [2:0] SIZE_WORD = 3'd2;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   haddr_q, haddr_d;
  logic                hwrite_q, hwrite_d;
  logic [2:0]          hsize_q, hsize_d;
  logic [31:0]         hwdata_q, hwdata_d;
  logic [1:0]          lane_q, lane_d;
  logic                unsigned_q, unsigned_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [2:0]          size_req;
  logic [ADDR_W-1:0]   req_addr;
  logic                misalign_trap;
  logic [31:0]         store_rep;
  logic [31:0]         load_ext;
  logic [7:0]          load_byte;
  logic [15:0]         load_half;

  // byte_control encoding 3 falls back to a word access.
  always_comb begin
    case (byte_control)
      2'd1:    size_req = SIZE_HALF;
      2'd2:    size_req = SIZE_BYTE;
      default: size_req = SIZE_WORD;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    req_addr      = addr;
    misalign_trap = ((size_req == SIZE_HALF) && addr[0]) ||
                    ((size_req == SIZE_WORD) && (addr[1:0] != 2'b00));
  end
`else
  // No trap: misaligned requests are silently aligned down to the access size.
  always_comb begin
    req_addr      = addr;
    misalign_trap = 1'b0;
    if (size_req == SIZE_HALF) begin
      req_addr[0] = 1'b0;
    end else if (size_req == SIZE_WORD) begin
      req_addr[1:0] = 2'b00;
    end
  end
`endif

  // Stores replicate the operand across every lane so the slave can pick the
  // lane addressed by HADDR without any shifting on our side. wdata is held
  // by the core until done, so it is still valid when the address phase ends.
  always_comb begin
    case (hsize_q)
      SIZE_BYTE: store_rep = {4{wdata[7:0]}};
      SIZE_HALF: store_rep = {2{wdata[15:0]}};
      default:   store_rep = wdata;
    endcase
  end

  // Little-endian lane select followed by sign/zero extension.
  always_comb begin
    case (lane_q)
      2'd0:    load_byte = HRDATA[7:0];
      2'd1:    load_byte = HRDATA[15:8];
      2'd2:    load_byte = HRDATA[23:16];
      default: load_byte = HRDATA[31:24];
    endcase
    load_half = lane_q[1] ? HRDATA[31:16] : HRDATA[15:0];
    case (hsize_q)
      SIZE_BYTE: load_ext = unsigned_q ? {24'h0, load_byte}
                                       : {{24{load_byte[7]}}, load_byte};
      SIZE_HALF: load_ext = unsigned_q ? {16'h0, load_half}
                                       : {{16{load_half[15]}}, load_half};
      default:   load_ext = HRDATA;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    haddr_d    = haddr_q;
    hwrite_d   = hwrite_q;
    hsize_d    = hsize_q;
    hwdata_d   = hwdata_q;
    lane_d     = lane_q;
    unsigned_d = unsigned_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (misalign_trap) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            haddr_d    = req_addr;
            hwrite_d   = mem_write;
            hsize_d    = size_req;
            lane_d     = req_addr[1:0];
            unsigned_d = arith_u;
            state_d    = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          hwdata_d = store_rep;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (HREADY) begin
          state_d = S_DONE;
          if (HRESP) begin
            // Second cycle of the two-cycle ERROR response.
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            err_d = 1'b0;
            if (!hwrite_q) begin
              rdata_d = load_ext;
            end
          end
        end
      end
      default: begin
        // DONE: the core advances on this edge; never relaunch from here.
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      haddr_q    <= '0;
      hwrite_q   <= 1'b0;
      hsize_q    <= 3'd0;
      hwdata_q   <= 32'h0;
      lane_q     <= 2'd0;
      unsigned_q <= 1'b0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      haddr_q    <= haddr_d;
      hwrite_q   <= hwrite_d;
      hsize_q    <= hsize_d;
      hwdata_q   <= hwdata_d;
      lane_q     <= lane_d;
      unsigned_q <= unsigned_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign stall  = rst_n & (((state_q == S_IDLE) & req_valid) |
                           (state_q == S_ADDR) | (state_q == S_DATA));
  assign done   = (state_q == S_DONE);
  assign HTRANS = (state_q == S_ADDR) ? 2'b10 : 2'b00;
  assign HADDR  = haddr_q;
  assign HWRITE = hwrite_q;
  assign HSIZE  = hsize_q;
  assign HWDATA = hwdata_q;
  assign rdata  = rdata_q;
  assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lsu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_lsu_sequencer
// Description : Directed self-checking bench for ahb_lsu_sequencer. Each
//               transfer is walked cycle by cycle against a hand-derived
//               timeline (IDLE, ADDR phase, DATA phase, DONE).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_lsu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        mem_write;
  logic [1:0]  byte_control;
  logic        arith_u;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int checks = 0;
  int errors = 0;

  ahb_lsu_sequencer #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .mem_write(mem_write),
    .byte_control(byte_control), .arith_u(arith_u), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // Entered and left at posedge+1. aw/dw are wait states in the address and
  // data phases; berr makes the last two data-phase cycles an ERROR response
  // (needs dw >= 1); trap means the bench expects no bus transfer at all.
  task automatic run_xfer(input string tag, input logic wr, input logic [1:0] bc,
                          input logic u, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] hrd, input int aw, input int dw,
                          input logic berr, input logic trap,
                          input logic [31:0] e_haddr, input logic [2:0] e_hsize,
                          input logic [31:0] e_hwdata, input logic [31:0] e_rdata,
                          input logic e_err);
    int n_addr;
    int n_data;
    int done_idx;
    n_addr   = trap ? 0 : aw + 1;
    n_data   = trap ? 0 : dw + 1;
    done_idx = 1 + n_addr + n_data;
    for (int k = 0; k <= done_idx; k++) begin
      req_valid    = 1'b1;
      mem_write    = wr;
      byte_control = bc;
      arith_u      = u;
      addr         = a;
      wdata        = wd;
      HREADY       = 1'b1;
      HRESP        = 1'b0;
      HRDATA       = 32'h0BAD_F00D;
      if (k >= 1 && k <= n_addr) begin
        HREADY = (k == n_addr);
      end else if (k > n_addr && k < done_idx) begin
        HREADY = ((k - n_addr - 1) == dw);
        HRESP  = berr && ((k - n_addr - 1) >= dw - 1);
        if (HREADY) HRDATA = hrd;
      end
      @(negedge clk);
      check_eq({tag, ".stall"}, {31'h0, stall}, {31'h0, (k < done_idx)});
      check_eq({tag, ".done"}, {31'h0, done}, {31'h0, (k == done_idx)});
      if (k >= 1 && k <= n_addr) begin
        check_eq({tag, ".htrans"}, {30'h0, HTRANS}, 32'h2);
        check_eq({tag, ".haddr"}, HADDR, e_haddr);
        check_eq({tag, ".hsize"}, {29'h0, HSIZE}, {29'h0, e_hsize});
        check_eq({tag, ".hwrite"}, {31'h0, HWRITE}, {31'h0, wr});
      end else begin
        check_eq({tag, ".htrans"}, {30'h0, HTRANS}, 32'h0);
      end
      if (wr && k > n_addr && k < done_idx) begin
        check_eq({tag, ".hwdata"}, HWDATA, e_hwdata);
      end
      if (k == done_idx) begin
        check_eq({tag, ".rdata"}, rdata, e_rdata);
        check_eq({tag, ".err"}, {31'h0, err}, {31'h0, e_err});
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    @(negedge clk);
    check_eq({tag, ".idle_done"}, {31'h0, done}, 32'h0);
    check_eq({tag, ".idle_stall"}, {31'h0, stall}, 32'h0);
    check_eq({tag, ".idle_rdata"}, rdata, e_rdata);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b1; mem_write = 1'b0; byte_control = 2'd0;
    arith_u = 1'b0; addr = 32'h0; wdata = 32'h0;
    HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst.stall", {31'h0, stall}, 32'h0);
    check_eq("rst.htrans", {30'h0, HTRANS}, 32'h0);
    check_eq("rst.haddr", HADDR, 32'h0);
    check_eq("rst.hwrite", {31'h0, HWRITE}, 32'h0);
    check_eq("rst.hsize", {29'h0, HSIZE}, 32'h0);
    check_eq("rst.hwdata", HWDATA, 32'h0);
    check_eq("rst.rdata", rdata, 32'h0);
    check_eq("rst.done", {31'h0, done}, 32'h0);
    check_eq("rst.err", {31'h0, err}, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk); #1;

    // lw 0x100, zero wait states
    run_xfer("lw", 1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0, 1'b0,
             32'h100, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0);
    // lb / lbu from lane 3
    run_xfer("lb", 1'b0, 2'd2, 1'b0, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 1'b0, 1'b0,
             32'h103, 3'd0, 32'h0, 32'hFFFFFF80, 1'b0);
    run_xfer("lbu", 1'b0, 2'd2, 1'b1, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 1'b0, 1'b0,
             32'h103, 3'd0, 32'h0, 32'h00000080, 1'b0);
    // sh with two data-phase wait states; rdata unchanged by a store
    run_xfer("sh", 1'b1, 2'd1, 1'b0, 32'h202, 32'h0000A5C3, 32'h0, 0, 2, 1'b0, 1'b0,
             32'h202, 3'd1, 32'hA5C3A5C3, 32'h00000080, 1'b0);
    // sw with two-cycle ERROR response
    run_xfer("sw_err", 1'b1, 2'd0, 1'b0, 32'h300, 32'h11223344, 32'h0, 0, 1, 1'b1, 1'b0,
             32'h300, 3'd2, 32'h11223344, 32'h0, 1'b1);
    // lh upper half with one address-phase wait state
    run_xfer("lh", 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h80FF1234, 1, 0, 1'b0, 1'b0,
             32'h102, 3'd1, 32'h0, 32'hFFFF80FF, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    run_xfer("lw_mis", 1'b0, 2'd0, 1'b0, 32'h102, 32'h0, 32'h12345678, 0, 0, 1'b0, 1'b1,
             32'h0, 3'd2, 32'h0, 32'hFFFF80FF, 1'b1);
`else
    run_xfer("lw_mis", 1'b0, 2'd0, 1'b0, 32'h102, 32'h0, 32'h12345678, 0, 0, 1'b0, 1'b0,
             32'h100, 3'd2, 32'h0, 32'h12345678, 1'b0);
`endif
    // sb replicates the low byte; byte_control 3 below is a word store
`ifdef LSU_MISALIGN_TRAP_EN
    run_xfer("sb", 1'b1, 2'd2, 1'b0, 32'h101, 32'h1234565A, 32'h0, 0, 0, 1'b0, 1'b0,
             32'h101, 3'd0, 32'h5A5A5A5A, 32'hFFFF80FF, 1'b0);
`else
    run_xfer("sb", 1'b1, 2'd2, 1'b0, 32'h101, 32'h1234565A, 32'h0, 0, 0, 1'b0, 1'b0,
             32'h101, 3'd0, 32'h5A5A5A5A, 32'h12345678, 1'b0);
`endif
    run_xfer("lw_bc3", 1'b0, 2'd3, 1'b0, 32'h108, 32'h0, 32'hCAFEF00D, 0, 0, 1'b0, 1'b0,
             32'h108, 3'd2, 32'h0, 32'hCAFEF00D, 1'b0);

    // Reset in the data phase while the slave is stalling
    req_valid = 1'b1; mem_write = 1'b0; byte_control = 2'd0; arith_u = 1'b0;
    addr = 32'h400; HREADY = 1'b1; HRESP = 1'b0;
    @(posedge clk); #1;          // now ADDR
    @(posedge clk); #1;          // now DATA
    HREADY = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    check_eq("rstmid.stall_low", {31'h0, stall}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = 1'b0; HREADY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("rstmid.htrans", {30'h0, HTRANS}, 32'h0);
      check_eq("rstmid.done", {31'h0, done}, 32'h0);
      check_eq("rstmid.stall", {31'h0, stall}, 32'h0);
      check_eq("rstmid.rdata", rdata, 32'h0);
      @(posedge clk); #1;
    end
    // Fresh request after reset completes normally
    run_xfer("lhu", 1'b0, 2'd1, 1'b1, 32'h206, 32'h0, 32'hBEEF0000, 0, 0, 1'b0, 1'b0,
             32'h206, 3'd1, 32'h0, 32'h0000BEEF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
